// File: rtl/clkmon_pkg.sv
// Shared types and defaults for the clock edge monitor.
package clkmon_pkg;

  localparam int unsigned CLKMON_CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    CHECK,
    LOCKED,
    STUCK
  } clkmon_state_t;

endpackage

// File: rtl/global_if.sv
// Global control signals shared across blocks; reset is synchronous, active-high.
interface global_if;

  logic reset;

  modport sink (input reset);

endinterface

// File: rtl/bit_synchronizer.sv
// Generic N-flop single-bit synchronizer, cleared to 0 by the global reset.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic   clk_in,
  global_if.sink glb,
  input  logic   d,
  output logic   q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (glb.reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_edge_monitor.sv
// Monitors a slow clock as data: edge strobes, period measurement, lock and stuck detection.
// Optional high-phase measurement (high_time port) is built when CLKMON_DUTY_EN is defined.
module clock_edge_monitor
  import clkmon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = CLKMON_CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic             clk_in,
  global_if.sink           glb,
  input  logic             mon_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stuck
`ifdef CLKMON_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             sync_q;
  logic             prev_q;
  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next_c;
  logic             timeout_c;
  logic [CNT_W-1:0] last_period_q;
  logic [CNT_W-1:0] last_period_d;
  clkmon_state_t    state_q;
  clkmon_state_t    state_d;
  logic [CNT_W-1:0] period_d;
  logic             period_valid_d;
  logic             locked_d;
  logic             stuck_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .glb    (glb),
    .d      (mon_clk),
    .q      (sync_q)
  );

  // Single-bit history makes rise and fall mutually exclusive.
  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

  // Cycle counter restarts on each rise and saturates instead of wrapping.
  always_comb begin
    cnt_next_c = cnt_q;
    if (rise_c) begin
      cnt_next_c = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_next_c = cnt_q + CNT_W'(1);
    end
  end

  // A rise in the same cycle always beats the timeout.
  assign timeout_c = !rise_c && (cnt_next_c == TIMEOUT_C) && (state_q != STUCK);

  always_comb begin
    state_d        = state_q;
    period_d       = period;
    period_valid_d = 1'b0;
    locked_d       = locked;
    stuck_d        = stuck;
    last_period_d  = last_period_q;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise_c) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          last_period_d  = cnt_q;
          state_d        = CHECK;
        end
      end
      CHECK: begin
        if (rise_c) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (cnt_q == last_period_q) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            last_period_d = cnt_q;
          end
        end
      end
      LOCKED: begin
        if (rise_c) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (cnt_q != last_period_q) begin
            state_d       = CHECK;
            locked_d      = 1'b0;
            last_period_d = cnt_q;
          end
        end
      end
      STUCK: begin
        // The first rise after a stall only restarts measurement.
        if (rise_c) begin
          state_d = MEASURE;
          stuck_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_c) begin
      state_d  = STUCK;
      stuck_d  = 1'b1;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (glb.reset) begin
      prev_q        <= 1'b0;
      cnt_q         <= '0;
      last_period_q <= '0;
      state_q       <= IDLE;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
      period        <= '0;
      period_valid  <= 1'b0;
      locked        <= 1'b0;
      stuck         <= 1'b0;
    end else begin
      prev_q        <= sync_q;
      cnt_q         <= cnt_next_c;
      last_period_q <= last_period_d;
      state_q       <= state_d;
      rise_pulse    <= rise_c;
      fall_pulse    <= fall_c;
      period        <= period_d;
      period_valid  <= period_valid_d;
      locked        <= locked_d;
      stuck         <= stuck_d;
    end
  end

`ifdef CLKMON_DUTY_EN
  logic [CNT_W-1:0] high_cnt_q;

  // High phase spans rise_pulse to fall_pulse; both strobes share the same latency.
  always_ff @(posedge clk_in) begin
    if (glb.reset) begin
      high_cnt_q <= '0;
      high_time  <= '0;
    end else begin
      if (rise_pulse) begin
        high_cnt_q <= CNT_W'(1);
      end else if (high_cnt_q != CNT_MAX) begin
        high_cnt_q <= high_cnt_q + CNT_W'(1);
      end
      if (fall_pulse) begin
        high_time <= high_cnt_q;
      end
    end
  end
`endif

endmodule
